// File: rtl/stream_parity_pkg.sv
// Shared types and constants for the stream parity block.
package stream_parity_pkg;

  // Frame FSM: no word yet, words accumulating, result presented.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // Parity mode encodings as seen on odd_mode.
  localparam logic MODE_EVEN = 1'b0;
  localparam logic MODE_ODD  = 1'b1;

  // Odd parity is the inverted XOR, so the mode bit folds in with one XOR.
  function automatic logic apply_mode(input logic acc, input logic mode);
    return acc ^ mode;
  endfunction

endpackage

// File: rtl/stream_parity_word_parity.sv
// Combinational reduction XOR of one input word.
module word_parity #(
  parameter int WIDTH = 7
) (
  input  logic [WIDTH-1:0] data,
  output logic             parity
);

  assign parity = ^data;

endmodule

// File: rtl/stream_parity.sv
// Per-frame parity and word count over a valid/ready word stream.
module stream_parity
  import stream_parity_pkg::*;
#(
  parameter int WIDTH = 7,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             odd_mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_parity,
  output logic [CNT_W-1:0] out_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_reg, state_next;
  logic             acc_reg, acc_next;
  logic             mode_reg, mode_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             out_valid_reg, out_valid_next;
  logic             out_parity_reg, out_parity_next;
  logic [CNT_W-1:0] out_count_reg, out_count_next;

  logic             word_par;
  logic             beat_fire;
  logic             frame_mode;
  logic             acc_upd;
  logic [CNT_W-1:0] cnt_upd;

  word_parity #(.WIDTH(WIDTH)) u_word_parity (
    .data   (in_data),
    .parity (word_par)
  );

  // Ready comes from the state register; held low while reset is asserted
  // so no beat can be accepted during reset.
  assign in_ready   = (state_reg != HOLD) && !rst;
  assign beat_fire  = in_valid && in_ready;
  // The first word of a frame uses the live mode; later words use the latch.
  assign frame_mode = (state_reg == IDLE) ? odd_mode : mode_reg;
  assign acc_upd    = acc_reg ^ word_par;
  assign cnt_upd    = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + CNT_W'(1);

  assign out_valid  = out_valid_reg;
  assign out_parity = out_parity_reg;
  assign out_count  = out_count_reg;

  // State, accumulator, counter, latched mode and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      acc_reg        <= 1'b0;
      mode_reg       <= MODE_EVEN;
      cnt_reg        <= '0;
      out_valid_reg  <= 1'b0;
      out_parity_reg <= 1'b0;
      out_count_reg  <= '0;
    end else begin
      state_reg      <= state_next;
      acc_reg        <= acc_next;
      mode_reg       <= mode_next;
      cnt_reg        <= cnt_next;
      out_valid_reg  <= out_valid_next;
      out_parity_reg <= out_parity_next;
      out_count_reg  <= out_count_next;
    end
  end

  // Next-state and next-output decode for the frame FSM.
  always_comb begin
    state_next      = state_reg;
    acc_next        = acc_reg;
    mode_next       = mode_reg;
    cnt_next        = cnt_reg;
    out_valid_next  = out_valid_reg;
    out_parity_next = out_parity_reg;
    out_count_next  = out_count_reg;

    case (state_reg)
      IDLE, ACCUM: begin
        if (beat_fire) begin
          mode_next = frame_mode;
          if (in_last) begin
            // Final word: publish the result; the running state is cleared
            // once the consumer takes it.
            state_next      = HOLD;
            out_valid_next  = 1'b1;
            out_parity_next = apply_mode(acc_upd, frame_mode);
            out_count_next  = cnt_upd;
          end else begin
            state_next = ACCUM;
            acc_next   = acc_upd;
            cnt_next   = cnt_upd;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_next      = IDLE;
          acc_next        = 1'b0;
          cnt_next        = '0;
          out_valid_next  = 1'b0;
          out_parity_next = 1'b0;
          out_count_next  = '0;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_stream_parity.sv
// Directed-vector bench for stream_parity (WIDTH=7; CNT_W=8 and CNT_W=2).
module tb_stream_parity;
  import stream_parity_pkg::*;

  logic       clk;
  logic       rst;
  logic       odd_mode;
  logic       out_ready;

  logic       in_valid, in_last, in_ready;
  logic [6:0] in_data;
  logic       out_valid, out_parity;
  logic [7:0] out_count;

  logic       s_in_valid, s_in_last, s_in_ready;
  logic [6:0] s_in_data;
  logic       s_out_valid, s_out_parity;
  logic [1:0] s_out_count;

  int n_vec = 0;
  int n_err = 0;

  stream_parity #(.WIDTH(7), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .odd_mode(odd_mode),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_parity(out_parity), .out_count(out_count)
  );

  stream_parity #(.WIDTH(7), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .odd_mode(odd_mode),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data), .in_last(s_in_last),
    .out_valid(s_out_valid), .out_ready(out_ready),
    .out_parity(s_out_parity), .out_count(s_out_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count set bits and fold in the mode: the reference parity of a word.
  function automatic logic ref_par(input int d, input logic odd);
    int ones;
    ones = 0;
    for (int i = 0; i < 7; i++) ones += (d >> i) & 1;
    return ((ones % 2) == 1) ^ odd;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one beat for exactly one edge (in_ready assumed high).
  task automatic beat(input logic [6:0] d, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    n_vec++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_hold: in_ready=%b out_valid=%b, want 0 0", in_ready, out_valid);
    end
    rst = 1'b0;
    #1;
    n_vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_parity !== 1'b0 || out_count !== 8'd0) begin
      n_err++;
      $display("FAIL reset_release: rdy=%b vld=%b par=%b cnt=%0d, want 1 0 0 0",
               in_ready, out_valid, out_parity, out_count);
    end
    $display("reset: rdy=%b vld=%b", in_ready, out_valid);
  endtask

  task automatic test_single_words();
    odd_mode  = MODE_EVEN;
    out_ready = 1'b1;
    for (int d = 0; d < 128; d++) begin
      beat(7'(d), 1'b1);
      n_vec++;
      if (out_valid !== 1'b1 || out_parity !== ref_par(d, 1'b0) || out_count !== 8'd1) begin
        n_err++;
        $display("FAIL single_%0d: vld=%b par=%b cnt=%0d, want 1 %b 1",
                 d, out_valid, out_parity, out_count, ref_par(d, 1'b0));
      end
      step();
      n_vec++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        n_err++;
        $display("FAIL single_take_%0d: vld=%b rdy=%b, want 0 1", d, out_valid, in_ready);
      end
    end
    $display("single words: 128 frames done");
  endtask

  task automatic test_mode();
    out_ready = 1'b1;
    odd_mode = MODE_EVEN;
    beat(7'h55, 1'b1);
    n_vec++;
    if (out_parity !== 1'b0 || out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL mode_55_even: par=%b vld=%b, want 0 1", out_parity, out_valid);
    end
    $display("frame 55 even: par=%b", out_parity);
    step();
    odd_mode = MODE_ODD;
    beat(7'h55, 1'b1);
    n_vec++;
    if (out_parity !== 1'b1 || out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL mode_55_odd: par=%b vld=%b, want 1 1", out_parity, out_valid);
    end
    $display("frame 55 odd: par=%b", out_parity);
    step();
    // Latched odd, switched to even after the first word.
    odd_mode = MODE_ODD;
    beat(7'h01, 1'b0);
    odd_mode = MODE_EVEN;
    beat(7'h03, 1'b0);
    beat(7'h07, 1'b1);
    n_vec++;
    if (out_parity !== 1'b1 || out_count !== 8'd3) begin
      n_err++;
      $display("FAIL mode_latch_odd: par=%b cnt=%0d, want 1 3", out_parity, out_count);
    end
    $display("frame 01 03 07 latched odd: par=%b cnt=%0d", out_parity, out_count);
    step();
    // Latched even, switched to odd after the first word.
    odd_mode = MODE_EVEN;
    beat(7'h01, 1'b0);
    odd_mode = MODE_ODD;
    beat(7'h03, 1'b0);
    beat(7'h07, 1'b1);
    n_vec++;
    if (out_parity !== 1'b0 || out_count !== 8'd3) begin
      n_err++;
      $display("FAIL mode_latch_even: par=%b cnt=%0d, want 0 3", out_parity, out_count);
    end
    $display("frame 01 03 07 latched even: par=%b cnt=%0d", out_parity, out_count);
    step();
    odd_mode = MODE_EVEN;
  endtask

  task automatic test_multi_word();
    out_ready = 1'b1;
    beat(7'h01, 1'b0);
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_parity !== 1'b0 || out_count !== 8'd0) begin
      n_err++;
      $display("FAIL accum_outputs: vld=%b rdy=%b par=%b cnt=%0d, want 0 1 0 0",
               out_valid, in_ready, out_parity, out_count);
    end
    beat(7'h03, 1'b0);
    beat(7'h07, 1'b1);
    n_vec++;
    if (out_valid !== 1'b1 || out_parity !== 1'b0 || out_count !== 8'd3) begin
      n_err++;
      $display("FAIL multi_010307: vld=%b par=%b cnt=%0d, want 1 0 3", out_valid, out_parity, out_count);
    end
    $display("frame 01 03 07: par=%b cnt=%0d", out_parity, out_count);
    step();
    beat(7'h01, 1'b0);
    beat(7'h02, 1'b1);
    n_vec++;
    if (out_valid !== 1'b1 || out_parity !== 1'b0 || out_count !== 8'd2) begin
      n_err++;
      $display("FAIL multi_0102: vld=%b par=%b cnt=%0d, want 1 0 2", out_valid, out_parity, out_count);
    end
    $display("frame 01 02: par=%b cnt=%0d", out_parity, out_count);
    step();
    beat(7'h01, 1'b0);
    beat(7'h02, 1'b0);
    beat(7'h04, 1'b1);
    n_vec++;
    if (out_valid !== 1'b1 || out_parity !== 1'b1 || out_count !== 8'd3) begin
      n_err++;
      $display("FAIL multi_010204: vld=%b par=%b cnt=%0d, want 1 1 3", out_valid, out_parity, out_count);
    end
    $display("frame 01 02 04: par=%b cnt=%0d", out_parity, out_count);
    step();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    beat(7'h01, 1'b1);
    // Junk beats offered during HOLD must be ignored.
    in_valid = 1'b1;
    in_data  = 7'h03;
    in_last  = 1'b0;
    for (int c = 0; c < 5; c++) begin
      n_vec++;
      if (out_valid !== 1'b1 || out_parity !== 1'b1 || out_count !== 8'd1 || in_ready !== 1'b0) begin
        n_err++;
        $display("FAIL hold_cycle_%0d: vld=%b par=%b cnt=%0d rdy=%b, want 1 1 1 0",
                 c, out_valid, out_parity, out_count, in_ready);
      end
      step();
    end
    out_ready = 1'b1;
    step();
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_count !== 8'd0) begin
      n_err++;
      $display("FAIL hold_take: vld=%b rdy=%b cnt=%0d, want 0 1 0", out_valid, in_ready, out_count);
    end
    in_valid = 1'b0;
    beat(7'h01, 1'b1);
    n_vec++;
    if (out_parity !== 1'b1 || out_count !== 8'd1) begin
      n_err++;
      $display("FAIL after_hold: par=%b cnt=%0d, want 1 1", out_parity, out_count);
    end
    $display("backpressure: held 5 cycles, next frame cnt=%0d", out_count);
    step();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    beat(7'h01, 1'b0);
    beat(7'h02, 1'b0);
    rst = 1'b1;
    step();
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL midreset_during: vld=%b rdy=%b, want 0 0", out_valid, in_ready);
    end
    rst = 1'b0;
    #1;
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL midreset_after: vld=%b rdy=%b, want 0 1", out_valid, in_ready);
    end
    beat(7'h01, 1'b1);
    n_vec++;
    if (out_valid !== 1'b1 || out_parity !== 1'b1 || out_count !== 8'd1) begin
      n_err++;
      $display("FAIL midreset_next: vld=%b par=%b cnt=%0d, want 1 1 1", out_valid, out_parity, out_count);
    end
    $display("reset mid-frame, next frame 01: par=%b cnt=%0d", out_parity, out_count);
    step();
    // Reset while a result is pending discards it.
    out_ready = 1'b0;
    beat(7'h03, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    n_vec++;
    if (out_valid !== 1'b0 || out_parity !== 1'b0 || out_count !== 8'd0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL holdreset: vld=%b par=%b cnt=%0d rdy=%b, want 0 0 0 1",
               out_valid, out_parity, out_count, in_ready);
    end
    $display("reset in hold: vld=%b", out_valid);
    out_ready = 1'b1;
  endtask

  task automatic test_saturation();
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      s_in_valid = 1'b1;
      s_in_data  = 7'h01;
      s_in_last  = (i == 5);
      step();
    end
    s_in_valid = 1'b0;
    s_in_last  = 1'b0;
    n_vec++;
    if (s_out_valid !== 1'b1 || s_out_count !== 2'd3 || s_out_parity !== 1'b0) begin
      n_err++;
      $display("FAIL saturate: vld=%b cnt=%0d par=%b, want 1 3 0", s_out_valid, s_out_count, s_out_parity);
    end
    $display("6-word frame on 2-bit counter: cnt=%0d", s_out_count);
    step();
    n_vec++;
    if (s_out_valid !== 1'b0 || s_in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL saturate_take: vld=%b rdy=%b, want 0 1", s_out_valid, s_in_ready);
    end
  endtask

  initial begin
    rst        = 1'b1;
    odd_mode   = MODE_EVEN;
    out_ready  = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    in_last    = 1'b0;
    s_in_valid = 1'b0;
    s_in_data  = '0;
    s_in_last  = 1'b0;
    test_reset();
    test_single_words();
    test_mode();
    test_multi_word();
    test_backpressure();
    test_reset_mid();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/stream_parity.md
STREAM_PARITY -- requirements
Module: stream_parity

Interface
REQ-001 Parameter WIDTH, default 7: bits per input word, SHALL be >= 1.
REQ-002 Parameter CNT_W, default 8: width of the frame word counter, SHALL be >= 1.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 odd_mode  input  1  0 = even parity (XOR of all bits), 1 = odd parity (inverted XOR).
REQ-006 in_valid  input  1  in_data/in_last are valid.
REQ-007 in_ready  output  1  block accepts a word this cycle.
REQ-008 in_data  input  WIDTH  data word.
REQ-009 in_last  input  1  word is the final word of the frame.
REQ-010 out_valid  output  1  frame result available.
REQ-011 out_ready  input  1  consumer takes the result.
REQ-012 out_parity  output  1  frame parity per the mode latched for the frame.
REQ-013 out_count  output  CNT_W  number of words in the frame, saturating.

Function
REQ-014 Beat accepted SHALL mean in_valid & in_ready on a rising edge; result taken SHALL mean out_valid & out_ready.
REQ-015 FSM states SHALL be IDLE (no word of the current frame accepted), ACCUM (at least one word accepted, no last), HOLD (result presented).
REQ-016 in_ready SHALL be 1 in IDLE and ACCUM, and 0 in HOLD; out_valid SHALL be 1 only in HOLD.
REQ-017 On the first accepted beat of a frame (IDLE), odd_mode SHALL be latched for that frame; later odd_mode changes SHALL NOT affect that frame.
REQ-018 Accumulator SHALL be the XOR of the reduction-XOR of every accepted in_data in the frame; out_parity SHALL equal accumulator XOR latched odd_mode.
REQ-019 Word counter SHALL increment per accepted beat and saturate at 2^CNT_W-1 without wrapping.
REQ-020 Transitions: IDLE->ACCUM on an accepted beat with in_last=0; IDLE->HOLD or ACCUM->HOLD on an accepted beat with in_last=1; ACCUM stays in ACCUM on an accepted beat with in_last=0; HOLD->IDLE when the result is taken; no beat -> state held.
REQ-021 Latency: out_valid SHALL rise on the first cycle after the last beat is accepted, including single-word frames.
REQ-022 In HOLD, out_parity and out_count SHALL stay stable until the result is taken; in_valid SHALL be ignored.
REQ-023 After the result is taken, in_ready SHALL reassert in the next cycle (IDLE) with accumulator and counter cleared; no input beat is accepted in the same cycle as the take.
REQ-024 When out_valid=0, out_parity and out_count SHALL be 0.

Reset
REQ-025 rst=1 at a clock edge SHALL force IDLE, clear the accumulator, counter and latched mode, and drive out_valid=0, out_parity=0, out_count=0; in_ready SHALL be 1 on the first cycle after reset.
REQ-026 Reset mid-frame or in HOLD SHALL discard the partial frame or pending result with no output.
REQ-027 While rst=1, in_ready SHALL be 0 and no beat SHALL be accepted.

Structure
REQ-028 A shared package SHALL hold the FSM state enum (IDLE/ACCUM/HOLD) and the parity-mode constants (EVEN=0, ODD=1).
REQ-029 One sub-module, word_parity (WIDTH-bit reduction XOR, combinational), SHALL be instantiated for in_data.
REQ-030 The block SHALL use no latches; all outputs SHALL be registered except in_ready, which SHALL be decoded from the state register only.

Verification
REQ-031 WIDTH=7, even mode, 128 single-word frames in_data=0..127 with in_last=1, out_ready=1 -> each out_parity equals the XOR of all 7 bits, out_count=1, out_valid one cycle after each beat.
REQ-032 Single word 7'h55 with in_last=1 -> out_parity=0 in even mode and 1 in odd mode; odd_mode toggled mid-frame on a 3-word frame -> the mode latched at the first word applies.
REQ-033 Frame 7'h01, 7'h03, 7'h07 (last on 7'h07) in even mode -> out_parity=0, out_count=3; frame 7'h01, 7'h02 -> out_parity=0, out_count=2.
REQ-034 out_ready held 0 for 5 cycles after a frame completes -> out_valid stays 1, outputs stay stable, in_ready stays 0; out_ready=1 -> out_valid=0 and in_ready=1 on the next cycle.
REQ-035 CNT_W=2, 6-word frame -> out_count=3 (saturated); rst pulsed after 2 words of a frame -> no out_valid, and the next 1-word frame 7'h01 gives out_parity=1, out_count=1.
